// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: MSB-first framed bit stream into a single-entry valid/ready buffer.
// Optional even-parity trailer bit enabled by defining SWR_PARITY_EN.
module serial_word_receiver #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         clr,
  input  logic         sIn,
  input  logic         sValid,
  input  logic         sStart,
  output logic [W-1:0] q,
  output logic         qValid,
  input  logic         qReady,
  output logic         busy,
  output logic         overrun
`ifdef SWR_PARITY_EN
  ,
  output logic         parErr
`endif
);

  localparam int CW = $clog2(W + 2);
`ifdef SWR_PARITY_EN
  localparam int LAST = W + 1;
`else
  localparam int LAST = W;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]   sr_q, sr_d, sr_shift, word;
  logic [W-1:0]   q_q, q_d;
  logic           qv_q, qv_d;
  logic           ovr_q, ovr_d;
  logic           done;
`ifdef SWR_PARITY_EN
  logic           perr_q, perr_d;
`endif

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SWR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
`ifdef SWR_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    q_d      = q_q;
    qv_d     = qv_q;
    ovr_d    = ovr_q;
    done     = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    sr_shift = {sr_q[W-2:0], sIn};
`ifdef SWR_PARITY_EN
    perr_d   = perr_q;
    // Completion lands on the parity bit, so the word is already fully in sr.
    word     = sr_q;
`else
    word     = sr_shift;
`endif
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
      q_d     = '0;
      qv_d    = 1'b0;
      ovr_d   = 1'b0;
`ifdef SWR_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      if (sValid) begin
        if (sStart) begin
          // A start bit always (re)opens a frame, discarding any partial word.
          state_d = SHIFT;
          cnt_d   = CW'(1);
          sr_d    = sr_shift;
        end else if (state_q == SHIFT) begin
`ifdef SWR_PARITY_EN
          if (cnt_q != CW'(W)) sr_d = sr_shift;
`else
          sr_d = sr_shift;
`endif
          if (cnt_inc == CW'(LAST)) begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
`ifdef SWR_PARITY_EN
            if (sIn != ^sr_q) perr_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      if (done) begin
        if (!qv_q || qReady) begin
          q_d  = word;
          qv_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (qv_q && qReady) begin
        qv_d = 1'b0;
      end
    end
  end

  assign q       = q_q;
  assign qValid  = qv_q;
  assign busy    = (state_q == SHIFT);
  assign overrun = ovr_q;
`ifdef SWR_PARITY_EN
  assign parErr  = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed scenarios plus randomized frames against a word-level model.
module tb_serial_word_receiver;
  localparam int W = 8;
`ifdef SWR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic ck = 1'b0, rst = 1'b1, clr = 1'b0;
  logic sIn = 1'b0, sValid = 1'b0, sStart = 1'b0, qReady = 1'b0;
  logic [W-1:0] q;
  logic qValid, busy, overrun;
`ifdef SWR_PARITY_EN
  logic parErr;
`endif

  int nchk = 0, nfail = 0;

  // Word-level reference state for the randomized run
  logic [W-1:0] m_q;
  logic m_v, m_ovr, m_busy;

  serial_word_receiver #(.W(W)) dut (
    .ck(ck), .rst(rst), .clr(clr), .sIn(sIn), .sValid(sValid), .sStart(sStart),
    .q(q), .qValid(qValid), .qReady(qReady), .busy(busy), .overrun(overrun)
`ifdef SWR_PARITY_EN
    , .parErr(parErr)
`endif
  );

  always #5 ck = ~ck;

  task automatic bit_cyc(input logic v, input logic s, input logic b, input logic r);
    @(negedge ck);
    sValid = v; sStart = s; sIn = b; qReady = r;
    @(posedge ck);
    #1;
  endtask

  task automatic do_clr();
    @(negedge ck);
    clr = 1'b1; sValid = 1'b0; sStart = 1'b0; qReady = 1'b0;
    @(posedge ck);
    #1;
    @(negedge ck);
    clr = 1'b0;
  endtask

  // Sends one full frame; qReady is raised only on the completing bit.
  task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input int gap, input logic pb);
    logic last;
    for (int i = W - 1; i >= 0; i--) begin
      last = (i == 0) && !PAR;
      bit_cyc(1'b1, i == W - 1, w[i], last ? rdy_last : 1'b0);
      if (!last) begin
        nchk++;
        if (busy !== 1'b1) begin nfail++; $display("FAIL busy_mid w=%h bit=%0d got=%b exp=1", w, i, busy); end
      end
      if (!last) for (int g = 0; g < gap; g++) bit_cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    if (PAR) bit_cyc(1'b1, 1'b0, pb, rdy_last);
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] eq, input logic ev, input logic eb, input logic eo);
    nchk++;
    if (q !== eq || qValid !== ev || busy !== eb || overrun !== eo) begin
      nfail++;
      $display("FAIL %s got q=%h v=%b busy=%b ovr=%b exp q=%h v=%b busy=%b ovr=%b",
               nm, q, qValid, busy, overrun, eq, ev, eb, eo);
    end
  endtask

  task automatic test_reset();
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge ck);
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_word(8'hB2, 1'b0, 0, ^8'hB2);
    chk_out("single", 8'hB2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'h0F, 1'b0, 0, ^8'h0F);
    chk_out("overrun_drop", 8'hB2, 1'b1, 1'b0, 1'b1);
    bit_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("overrun_read", 8'hB2, 1'b0, 1'b0, 1'b1);
    bit_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("overrun_sticky", 8'hB2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_simul();
    do_clr();
    chk_out("clr", 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 0, ^8'hB2);
    chk_out("simul_first", 8'hB2, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b1, 0, ^8'h5A);
    chk_out("simul_replace", 8'h5A, 1'b1, 1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("simul_read", 8'h5A, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bit_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("restart_partial", 8'h5A, 1'b0, 1'b1, 1'b0);
    send_word(8'hC3, 1'b0, 2, ^8'hC3);
    chk_out("restart_word", 8'hC3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_rst_clr_mid();
    for (int i = 0; i < 5; i++) bit_cyc(1'b1, i == 0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 chk_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge ck);
    rst = 1'b0; sValid = 1'b0; sStart = 1'b0;
    send_word(8'hA5, 1'b0, 0, ^8'hA5);
    chk_out("rst_after", 8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_cyc(1'b1, i == 0, 1'b0, 1'b0);
    @(negedge ck);
    clr = 1'b1; sValid = 1'b1; sStart = 1'b1; sIn = 1'b1;
    #1 chk_out("clr_sync_wait", 8'hA5, 1'b1, 1'b1, 1'b0);
    @(posedge ck);
    #1 chk_out("clr_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge ck);
    clr = 1'b0; sValid = 1'b0; sStart = 1'b0;
    send_word(8'hA5, 1'b0, 0, ^8'hA5);
    chk_out("clr_after", 8'hA5, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef SWR_PARITY_EN
  task automatic test_parity();
    bit_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hB2, 1'b0, 0, 1'b0);
    chk_out("par_ok", 8'hB2, 1'b1, 1'b0, 1'b0);
    nchk++;
    if (parErr !== 1'b0) begin nfail++; $display("FAIL par_ok_flag got=%b exp=0", parErr); end
    send_word(8'h07, 1'b1, 0, 1'b0);
    chk_out("par_bad", 8'h07, 1'b1, 1'b0, 1'b0);
    nchk++;
    if (parErr !== 1'b1) begin nfail++; $display("FAIL par_bad_flag got=%b exp=1", parErr); end
  endtask
`endif

  // One randomized cycle; cmp marks the edge that completes a frame carrying word w.
  task automatic rcyc(input logic v, input logic s, input logic b, input bit cmp,
                      input logic [W-1:0] w, input logic eb);
    logic r;
    r = 1'($urandom_range(0, 1));
    bit_cyc(v, s, b, r);
    if (cmp) begin
      if (!m_v || r) begin m_q = w; m_v = 1'b1; end
      else m_ovr = 1'b1;
    end else if (m_v && r) begin
      m_v = 1'b0;
    end
    m_busy = eb;
    chk_out("random", m_q, m_v, m_busy, m_ovr);
  endtask

  task automatic gaps();
    int n;
    n = $urandom_range(0, 2);
    for (int g = 0; g < n; g++)
      rcyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, m_busy);
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic [W-1:0] bits_q[$];
    int k;
    do_clr();
    m_q = '0; m_v = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, W - 1);
        for (int i = 0; i < k; i++) begin
          rcyc(1'b1, i == 0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b1);
          gaps();
        end
      end
      w = W'($urandom);
      bits_q.delete();
      for (int i = W - 1; i >= 0; i--) bits_q.push_back({W{w[i]}});
      for (int i = 0; i < W; i++) begin
        if (i == W - 1 && !PAR) rcyc(1'b1, 1'b0, bits_q[i][0], 1'b1, w, 1'b0);
        else begin
          rcyc(1'b1, i == 0, bits_q[i][0], 1'b0, '0, 1'b1);
          gaps();
        end
      end
      if (PAR) rcyc(1'b1, 1'b0, ^w, 1'b1, w, 1'b0);
      gaps();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_simul();
    test_restart();
    test_rst_clr_mid();
`ifdef SWR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
